manch_tx_ctrl: RTL and testbench



---
 rtl/manch_tx_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_manch_tx_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/manch_tx_ctrl.sv
// rtl/manch_tx_ctrl.sv - Manchester TX frame sequencer (SOF, LSB-first data, optional odd parity, EOF guard)
//
// Optional feature macro: MANCH_TX_PARITY_EN (adds one odd-parity ETU per byte).
//
// Ports:
//   clk        fc/16 subcarrier clock, all logic on posedge
//   rst        asynchronous active-high reset
//   in_valid   payload byte present on in_byte
//   in_byte    payload byte
//   in_last    in_byte is the final byte of the frame
//   out_ready  holding register empty; byte taken when in_valid & out_ready
//   out_enable Manchester encoder enable
//   out_bit    encoder data bit, constant for a whole ETU
//   out_busy   controller not in IDLE
//   out_done   one-cycle pulse when a frame (including guard) completes
//   out_err    one-cycle pulse on underrun
module manch_tx_ctrl #(
    parameter int ETU_CLKS   = 8,
    parameter int GUARD_ETUS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    input  logic       in_last,
    output logic       out_ready,
    output logic       out_enable,
    output logic       out_bit,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_err
);

    localparam int EW   = (ETU_CLKS > 2) ? $clog2(ETU_CLKS) : 1;
    localparam int CMAX = (GUARD_ETUS > 8) ? GUARD_ETUS : 8;
    localparam int BW   = $clog2(CMAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_DATA,
        S_PAR,
        S_EOF
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [EW-1:0]  r_etu_cnt;
    logic [BW-1:0]  r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_cur_last;
    logic [7:0]     r_hold_byte;
    logic           r_hold_last;
    logic           r_hold_full;
    logic           r_done;
    logic           r_err;
`ifdef MANCH_TX_PARITY_EN
    logic           r_par;
`endif

    logic w_etu_end;
    logic w_accept;
    logic w_load;
    logic w_shift;
    logic w_eob;
    logic w_cnt_clr;
    logic w_set_done;
    logic w_set_err;
    logic w_enable;
    logic w_bit;

    assign w_etu_end = (r_etu_cnt == EW'(ETU_CLKS - 1));
    assign w_accept  = in_valid & ~r_hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_eob      = 1'b0;
        w_set_done = 1'b0;
        w_set_err  = 1'b0;
        w_enable   = 1'b0;
        w_bit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hold_full) begin
                    w_next = S_SOF;
                    w_load = 1'b1;
                end
            end
            S_SOF: begin
                w_enable = 1'b1;
                w_bit    = 1'b1;
                if (w_etu_end) w_next = S_DATA;
            end
            S_DATA: begin
                w_enable = 1'b1;
                w_bit    = r_shift[0];
                if (w_etu_end) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == BW'(7)) begin
`ifdef MANCH_TX_PARITY_EN
                        w_next = S_PAR;
`else
                        w_eob = 1'b1;
`endif
                    end
                end
            end
`ifdef MANCH_TX_PARITY_EN
            S_PAR: begin
                w_enable = 1'b1;
                w_bit    = ~r_par;
                if (w_etu_end) w_eob = 1'b1;
            end
`endif
            S_EOF: begin
                if (w_etu_end && (r_bit_cnt == BW'(GUARD_ETUS - 1))) begin
                    w_next     = S_IDLE;
                    w_set_done = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // End-of-byte decision uses the registered hold state, so a byte
        // accepted on this same edge cannot rescue an underrun.
        if (w_eob) begin
            if (r_cur_last) begin
                w_next = S_EOF;
            end else if (r_hold_full) begin
                w_next = S_DATA;
                w_load = 1'b1;
            end else begin
                w_next    = S_EOF;
                w_set_err = 1'b1;
            end
        end
        // Back-to-back DATA keeps the state but still restarts the bit count.
        w_cnt_clr = (w_next != r_state) || w_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_etu_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_cur_last  <= 1'b0;
            r_hold_byte <= '0;
            r_hold_last <= 1'b0;
            r_hold_full <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef MANCH_TX_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_done <= w_set_done;
            r_err  <= w_set_err;

            if (r_state == S_IDLE || w_etu_end) begin
                r_etu_cnt <= '0;
            end else begin
                r_etu_cnt <= r_etu_cnt + EW'(1);
            end

            if (w_cnt_clr) begin
                r_bit_cnt <= '0;
            end else if (w_etu_end && r_state != S_IDLE) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end

            if (w_load) begin
                r_shift    <= r_hold_byte;
                r_cur_last <= r_hold_last;
`ifdef MANCH_TX_PARITY_EN
                r_par      <= 1'b0;
`endif
            end else if (w_shift) begin
                r_shift <= {1'b0, r_shift[7:1]};
`ifdef MANCH_TX_PARITY_EN
                r_par   <= r_par ^ r_shift[0];
`endif
            end

            // Accept and load never coincide: load needs a full hold, accept an empty one.
            if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold_byte <= in_byte;
                r_hold_last <= in_last;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign out_ready  = ~r_hold_full;
    assign out_enable = w_enable;
    assign out_bit    = w_bit;
    assign out_busy   = (r_state != S_IDLE);
    assign out_done   = r_done;
    assign out_err    = r_err;

endmodule

// File: tb/tb_manch_tx_ctrl.sv
// tb/tb_manch_tx_ctrl.sv - directed self-checking bench for manch_tx_ctrl
module tb_manch_tx_ctrl;

    localparam int ETU   = 8;
    localparam int GUARD = 2;
`ifdef MANCH_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int TR = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready, out_enable, out_bit, out_busy, out_done, out_err;

    int checks = 0;
    int errors = 0;
    int both_cnt = 0;

    manch_tx_ctrl #(.ETU_CLKS(ETU), .GUARD_ETUS(GUARD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .out_ready (out_ready),
        .out_enable(out_enable),
        .out_bit   (out_bit),
        .out_busy  (out_busy),
        .out_done  (out_done),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    logic tr_en   [TR];
    logic tr_bit  [TR];
    logic tr_done [TR];
    logic tr_err  [TR];
    logic tr_acc  [TR];
    int   cyc = 0;

    always @(negedge clk) begin
        #1;
        if (cyc < TR) begin
            tr_en[cyc]   = out_enable;
            tr_bit[cyc]  = out_bit;
            tr_done[cyc] = out_done;
            tr_err[cyc]  = out_err;
            tr_acc[cyc]  = in_valid & out_ready;
            if (out_done && out_err) both_cnt = both_cnt + 1;
            cyc = cyc + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [7:0] b, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = l;
        while (out_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("offer_ready_wait", (n < 400), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (out_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (n < 3000), 1);
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [31:0] exp_bits(input logic [7:0] b0, input logic [7:0] b1, input int n);
        logic [31:0] v;
        logic [7:0]  b;
        int          k;
        v    = '0;
        v[0] = 1'b1;
        k    = 1;
        for (int j = 0; j < n; j++) begin
            b = (j == 0) ? b0 : b1;
            for (int t = 0; t < 8; t++) begin
                v[k] = b[t];
                k++;
            end
            if (P == 1) begin
                v[k] = ~^b;
                k++;
            end
        end
        return v;
    endfunction

    task automatic check_frame(input string tag, input int from, input logic [7:0] b0,
                               input logic [7:0] b1, input int n, input int exp_err_off,
                               output int fend);
        int f, len, unstable, done_gap, done_cnt, err_off;
        logic [31:0] bits;
        f = -1; len = 0; bits = '0; unstable = 0;
        done_gap = -1; done_cnt = 0; err_off = -1;
        for (int i = from; i < cyc && f < 0; i++) if (tr_en[i]) f = i;
        if (f >= 0) begin
            while (f + len < cyc && tr_en[f + len]) len++;
            for (int i = 0; i < len; i++) begin
                if ((i % ETU) == 0 && (i / ETU) < 32) bits[i / ETU] = tr_bit[f + i];
                if ((i % ETU) != 0 && tr_bit[f + i] !== tr_bit[f + i - 1]) unstable++;
            end
            for (int i = f; i < f + len + GUARD * ETU + 4 && i < cyc; i++) begin
                if (tr_done[i]) begin
                    done_cnt++;
                    if (done_gap < 0) done_gap = i - (f + len);
                end
                if (tr_err[i] && err_off < 0) err_off = i - f;
            end
        end
        chk({tag, ".len"}, len, ETU * (1 + n * (8 + P)));
        chk({tag, ".bits"}, bits, exp_bits(b0, b1, n));
        chk({tag, ".stable"}, unstable, 0);
        chk({tag, ".done_gap"}, done_gap, GUARD * ETU);
        chk({tag, ".done_cnt"}, done_cnt, 1);
        chk({tag, ".err_off"}, err_off, exp_err_off);
        fend = (f >= 0) ? f + len : from;
    endtask

    initial begin
        int s, fe, acc, pulses, n;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst.ready", out_ready, 1);
        chk("rst.enable", out_enable, 0);
        chk("rst.bit", out_bit, 0);
        chk("rst.busy", out_busy, 0);
        chk("rst.done", out_done, 0);
        chk("rst.err", out_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle.busy", out_busy, 0);

        // single byte 0xA5
        s = cyc;
        offer(8'hA5, 1'b1);
        wait_done("a5.timeout");
        check_frame("a5", s, 8'hA5, 8'h00, 1, -1, fe);

        // single byte 0x01 (parity ETU 0)
        s = cyc;
        offer(8'h01, 1'b1);
        wait_done("b01.timeout");
        check_frame("b01", s, 8'h01, 8'h00, 1, -1, fe);

        // two bytes back to back, second offered during the first
        s = cyc;
        offer(8'h00, 1'b0);
        offer(8'hFF, 1'b1);
        wait_done("two.timeout");
        check_frame("two", s, 8'h00, 8'hFF, 2, -1, fe);

        // underrun after one non-last byte
        s = cyc;
        offer(8'h3C, 1'b0);
        wait_done("under.timeout");
        check_frame("under", s, 8'h3C, 8'h00, 1, ETU * (9 + P), fe);
        chk("under.busy_after", out_busy, 0);

        // in_valid held high while out_ready=0: exactly one acceptance
        s = cyc;
        offer(8'h0F, 1'b1);
        in_valid = 1'b1;
        in_byte  = 8'h81;
        in_last  = 1'b1;
        repeat (30) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        acc = 0;
        for (int i = s; i < cyc; i++) if (tr_acc[i]) acc++;
        chk("hold.accepts", acc, 2);
        wait_done("hold.timeout1");
        wait_done("hold.timeout2");
        check_frame("hold1", s, 8'h0F, 8'h00, 1, -1, fe);
        check_frame("hold2", fe, 8'h81, 8'h00, 1, -1, fe);

        // asynchronous reset in the middle of DATA bit 4
        s = cyc;
        offer(8'hD3, 1'b0);
        n = 0;
        while (out_enable !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid.sof_seen", (n < 100), 1);
        offer(8'h99, 1'b1);
        repeat (ETU * 5 + 2) @(negedge clk);
        chk("rstmid.pre_enable", out_enable, 1);
        chk("rstmid.pre_bit", out_bit, 1);
        chk("rstmid.pre_ready", out_ready, 0);
        rst = 1'b1;
        #1;
        chk("rstmid.enable", out_enable, 0);
        chk("rstmid.bit", out_bit, 0);
        chk("rstmid.ready", out_ready, 1);
        chk("rstmid.busy", out_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rstmid.post_busy", out_busy, 0);
        chk("rstmid.post_ready", out_ready, 1);
        pulses = 0;
        for (int i = s; i < cyc; i++) if (tr_done[i] || tr_err[i]) pulses++;
        chk("rstmid.no_pulses", pulses, 0);
        s = cyc;
        offer(8'h55, 1'b1);
        wait_done("b55.timeout");
        check_frame("b55", s, 8'h55, 8'h00, 1, -1, fe);

        chk("done_err_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
